vga_pixel_fetch: RTL and testbench



---
 rtl/vga_pixel_fetch.sv | 112 +++++++++++
 tb/tb_vga_pixel_fetch.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: raster position to framebuffer reads, colour/sync pipeline alignment and tear-free buffer swap
module vga_pixel_fetch #(
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        active_in,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        display_buf,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);
    logic                  in_area;
    logic [14:0]           offset;
    logic                  vs_prev;
    logic                  vs_fall;
    logic                  do_swap;
    logic [RD_LATENCY-1:0] hs_pipe;
    logic [RD_LATENCY-1:0] vs_pipe;
    logic [RD_LATENCY-1:0] act_pipe;
    logic                  act_d;
    logic [3:0]            r_exp;
    logic [3:0]            g_exp;
    logic [3:0]            b_exp;

    // 4x downscale to the 160-wide framebuffer (160 = 128 + 32), visibility, and swap trigger
    always_comb begin
        in_area = (x < 10'd640) && (y < 10'd480);
        offset  = {y[9:2], 7'd0} + {2'd0, y[9:2], 5'd0} + {7'd0, x[9:2]};
        vs_fall = vs_prev & ~vsync_in;
        do_swap = vs_fall & swap_req;
    end

    // address stage: strobe inside the visible area, address held outside it
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd_en <= 1'b0;
            mem_addr  <= 16'd0;
        end else begin
            mem_rd_en <= in_area;
            if (in_area)
                mem_addr <= {display_buf, offset};
        end
    end

    // sync and active delay lines, one stage per clock of memory latency
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            act_pipe <= '0;
        end else begin
            hs_pipe[0]  <= hsync_in;
            vs_pipe[0]  <= vsync_in;
            act_pipe[0] <= active_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
                act_pipe[i] <= act_pipe[i-1];
            end
        end
    end

    // RRRGGGBB to 4-bit DAC codes by bit replication, blanked outside active video
    always_comb begin
        act_d = act_pipe[RD_LATENCY-1];
        r_exp = act_d ? {mem_data[7:5], mem_data[7]} : 4'd0;
        g_exp = act_d ? {mem_data[4:2], mem_data[4]} : 4'd0;
        b_exp = act_d ? {mem_data[1:0], mem_data[1:0]} : 4'd0;
    end

    // output register driving the DAC and connector syncs
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r  <= 4'd0;
            vga_g  <= 4'd0;
            vga_b  <= 4'd0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            vga_r  <= r_exp;
            vga_g  <= g_exp;
            vga_b  <= b_exp;
            vga_hs <= hs_pipe[RD_LATENCY-1];
            vga_vs <= vs_pipe[RD_LATENCY-1];
        end
    end

    // buffer swap only on the vsync falling edge; vs_prev resets low so reset never looks like an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev     <= 1'b0;
            swap_ack    <= 1'b0;
            display_buf <= 1'b0;
        end else begin
            vs_prev     <= vsync_in;
            swap_ack    <= do_swap;
            display_buf <= display_buf ^ do_swap;
        end
    end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: scoreboard bench over RD_LATENCY 1, 2 and 4 with a compressed randomized raster
module tb_vga_pixel_fetch;
    localparam int N = 3;

    typedef struct packed {
        int          due;
        logic        rd;
        logic [15:0] addr;
        logic        ack;
        logic        bf;
    } aexp_t;

    typedef struct packed {
        int         due;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } cexp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic       active_in = 1'b0;
    logic       swap_req = 1'b0;

    logic        ack_w  [N];
    logic        buf_w  [N];
    logic        rd_w   [N];
    logic [15:0] addr_w [N];
    logic [7:0]  data_w [N];
    logic [3:0]  r_w    [N];
    logic [3:0]  g_w    [N];
    logic [3:0]  b_w    [N];
    logic        hs_w   [N];
    logic        vs_w   [N];

    logic [7:0] fb [65536];

    int cyc = 0;
    int sh [N] = '{0, 0, 0};
    int n_cmp = 0;
    int n_fail = 0;

    aexp_t aq [$];
    cexp_t cq [N][$];
    aexp_t ae;
    cexp_t ce;

    logic        m_buf = 1'b0;
    logic        m_pvs = 1'b0;
    logic [15:0] m_addr = '0;
    logic        p_hs = 1'b0;
    logic        p_vs = 1'b0;
    logic        p_act = 1'b0;
    logic        drop = 1'b0;
    logic        req_at_fall = 1'b0;
    int          hold = 0;

    function automatic int lat_of(input int k);
        return k == 0 ? 1 : k == 1 ? 2 : 4;
    endfunction

    function automatic logic [11:0] expand(input logic [7:0] d);
        int r3, g3, b2;
        r3 = int'(d) / 32;
        g3 = (int'(d) / 4) % 8;
        b2 = int'(d) % 4;
        return {4'(r3 * 2 + r3 / 4), 4'(g3 * 2 + g3 / 4), 4'(b2 * 5)};
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int L = g == 0 ? 1 : g == 1 ? 2 : 4;
        logic [15:0] ap [L];
        vga_pixel_fetch #(.RD_LATENCY(L)) dut (
            .clk(clk),
            .rst(rst),
            .x(x),
            .y(y),
            .hsync_in(hsync_in),
            .vsync_in(vsync_in),
            .active_in(active_in),
            .swap_req(swap_req),
            .swap_ack(ack_w[g]),
            .display_buf(buf_w[g]),
            .mem_addr(addr_w[g]),
            .mem_rd_en(rd_w[g]),
            .mem_data(data_w[g]),
            .vga_r(r_w[g]),
            .vga_g(g_w[g]),
            .vga_b(b_w[g]),
            .vga_hs(hs_w[g]),
            .vga_vs(vs_w[g])
        );
        // fixed-latency framebuffer: data for an address appears L clocks after it is registered
        always @(posedge clk) begin
            ap[0] <= addr_w[g];
            for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
        end
        assign data_w[g] = fb[ap[L-1]];
    end

    // edge counter and per-latency reset shadow (outputs sit at reset values for L+1 edges)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < N; k++)
            sh[k] <= rst ? lat_of(k) + 1 : (sh[k] > 0 ? sh[k] - 1 : 0);
    end

    task automatic chk(input string nm, input int k, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s lat%0d edge%0d: got %0h expected %0h", nm, lat_of(k), cyc, got, exp);
        end
    endtask

    // monitor: pops whatever is due at this edge and compares every instance
    always @(negedge clk) begin
        if (aq.size() > 0 && aq[0].due == cyc) begin
            ae = aq.pop_front();
            for (int k = 0; k < N; k++) begin
                chk("mem_rd_en", k, 16'(rd_w[k]), 16'(ae.rd));
                chk("mem_addr", k, addr_w[k], ae.addr);
                chk("swap_ack", k, 16'(ack_w[k]), 16'(ae.ack));
                chk("display_buf", k, 16'(buf_w[k]), 16'(ae.bf));
            end
        end
        for (int k = 0; k < N; k++) begin
            logic have;
            have = cq[k].size() > 0 && cq[k][0].due == cyc;
            if (have) ce = cq[k].pop_front();
            if (sh[k] > 0) begin
                ce.r = 4'd0;
                ce.g = 4'd0;
                ce.b = 4'd0;
                ce.hs = 1'b1;
                ce.vs = 1'b1;
            end
            if (have || sh[k] > 0) begin
                chk("vga_r", k, 16'(r_w[k]), 16'(ce.r));
                chk("vga_g", k, 16'(g_w[k]), 16'(ce.g));
                chk("vga_b", k, 16'(b_w[k]), 16'(ce.b));
                chk("vga_hs", k, 16'(hs_w[k]), 16'(ce.hs));
                chk("vga_vs", k, 16'(vs_w[k]), 16'(ce.vs));
            end
        end
    end

    // drive one raster position (syncs of the previous position go out alongside) and predict its results
    task automatic px(input int xv, input int yv, input logic h, input logic v, input logic a, input logic r);
        int s;
        logic fall, ak, in_a;
        logic [15:0] pa;
        logic [11:0] c;
        s = cyc + 1;
        if (drop) begin
            if (hold == 0) begin
                swap_req = 1'b0;
                drop = 1'b0;
            end else hold--;
        end
        fall = m_pvs && !p_vs;
        if (req_at_fall && fall) swap_req = 1'b1;
        x = 10'(xv);
        y = 10'(yv);
        hsync_in = p_hs;
        vsync_in = p_vs;
        active_in = p_act;
        rst = r;
        in_a = xv < 640 && yv < 480;
        ak = !r && fall && swap_req;
        pa = {m_buf, 15'((yv / 4) * 160 + xv / 4)};
        if (r) m_addr = 16'd0;
        else if (in_a) m_addr = pa;
        m_buf = r ? 1'b0 : m_buf ^ ak;
        m_pvs = r ? 1'b0 : p_vs;
        aq.push_back(aexp_t'{s, !r && in_a, m_addr, ak, m_buf});
        c = a ? expand(fb[pa]) : 12'd0;
        for (int k = 0; k < N; k++)
            cq[k].push_back(cexp_t'{s + lat_of(k) + 1, c[11:8], c[7:4], c[3:0], h, v});
        if (ak) begin
            drop = 1'b1;
            hold = $urandom_range(0, 2);
            req_at_fall = 1'b0;
        end
        p_hs = h;
        p_vs = v;
        p_act = a;
        @(posedge clk);
        #2;
    endtask

    // compressed frame: 40 positions per line (x step 20), 27 lines (y step 20), vsync on line 25
    task automatic frame(input int req_v, input int req_h, input int rst_v, input int rst_h);
        if (req_v == -2) req_at_fall = 1'b1;
        for (int v = 0; v < 27; v++) begin
            int jy;
            jy = v == 0 ? 0 : $urandom_range(0, 19);
            for (int h = 0; h < 40; h++) begin
                int jx;
                jx = h == 0 ? 0 : $urandom_range(0, 19);
                if (v == rst_v && h == rst_h) begin
                    px(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
                    px(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
                end
                if (v == req_v && h == req_h) swap_req = 1'b1;
                px(h * 20 + jx, v * 20 + jy, !(h >= 33 && h <= 36), v != 25, h < 32 && v < 24, 1'b0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) fb[i] = 8'($urandom);
        fb[162] = 8'b111_000_11;
        for (int i = 0; i < 4; i++) px(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        px(8, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        px(8, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        px(639, 479, 1'b1, 1'b1, 1'b1, 1'b0);
        px(640, 479, 1'b1, 1'b1, 1'b0, 1'b0);
        px(700, 10, 1'b1, 1'b1, 1'b0, 1'b0);
        px(8, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        frame(5, 3, -1, -1);
        frame(10, 0, 20, 5);
        frame(25, 5, 25, 10);
        frame(-1, -1, -1, -1);
        frame(-2, -1, -1, -1);
        frame(-1, -1, -1, -1);
        frame($urandom_range(0, 23), $urandom_range(0, 39), -1, -1);
        frame($urandom_range(0, 23), $urandom_range(0, 39), -1, -1);
        for (int i = 0; i < 8; i++) px(700, 500, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
